// File: rtl/bf16_acc.sv
// Sequential bfloat16 accumulator for the MAC path: sums a programmed number of
// multiplier products through an align / add / normalize datapath with sticky status.
module bf16_acc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_exc,
    input  logic             in_ovf,
    input  logic             in_unf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_exc,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, ACCEPT, ALIGN, ADD, NORM, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [15:0]      acc, acc_nxt, out_nxt;
    logic             exc_f, ovf_f, unf_f, exc_nxt, ovf_nxt, unf_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic             t_s, t_zero, t_exc, t_ovf;
    logic [7:0]       t_e;
    logic [6:0]       t_m;

    logic             a_s, a_s_nxt, a_sub, a_sub_nxt;
    logic [7:0]       a_e, a_e_nxt;
    logic [9:0]       a_x, a_x_nxt, a_y, a_y_nxt;

    logic             x_is_acc, x_s, y_s, go_norm;
    logic [7:0]       x_e, y_e, d;
    logic [6:0]       x_m, y_m;
    logic [9:0]       y_sig, diff, res_sig, sig_sh;
    logic [10:0]      sum;
    logic [7:0]       e_inc, e_dec;

    // Larger magnitude becomes X; equal magnitudes keep the accumulator as X.
    always_comb begin
        x_is_acc = (acc[14:0] >= {t_e, t_m});
        if (x_is_acc) begin
            x_s = acc[15]; x_e = acc[14:7]; x_m = acc[6:0];
            y_s = t_s;     y_e = t_e;       y_m = t_m;
        end else begin
            x_s = t_s;     x_e = t_e;       x_m = t_m;
            y_s = acc[15]; y_e = acc[14:7]; y_m = acc[6:0];
        end
        d     = x_e - y_e;
        y_sig = '0;
        if (y_e != 8'd0 && d < 8'd10)
            y_sig = {1'b1, y_m, 2'b00} >> d;
    end

    assign sum     = {1'b0, a_x} + {1'b0, a_y};
    assign diff    = a_x - a_y;
    assign res_sig = a_sub ? diff : (sum[10] ? sum[10:1] : sum[9:0]);
    assign sig_sh  = {a_x[8:0], 1'b0};
    assign e_inc   = a_e + 8'd1;
    assign e_dec   = a_e - 8'd1;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        exc_nxt   = exc_f;
        ovf_nxt   = ovf_f;
        unf_nxt   = unf_f;
        cnt_nxt   = cnt;
        a_s_nxt   = a_s;
        a_e_nxt   = a_e;
        a_x_nxt   = a_x;
        a_y_nxt   = a_y;
        a_sub_nxt = a_sub;
        go_norm   = 1'b0;
        case (state)
            IDLE: ;
            ACCEPT: if (in_valid) state_nxt = ALIGN;
            ALIGN: begin
                a_s_nxt   = x_s;
                a_e_nxt   = x_e;
                a_x_nxt   = {1'b1, x_m, 2'b00};
                a_y_nxt   = y_sig;
                a_sub_nxt = x_s ^ y_s;
                state_nxt = ADD;
            end
            ADD: begin
                cnt_nxt = cnt - CNT_ONE;
                exc_nxt = exc_f | t_exc;
                ovf_nxt = ovf_f | t_ovf;
                a_x_nxt = res_sig;
                // Once the run is poisoned the accumulator is frozen.
                if (!exc_f && !ovf_f && !t_exc) begin
                    if (t_ovf) begin
                        acc_nxt = {t_s, 8'hFF, 7'h00};
                    end else if (!t_zero) begin
                        if (!a_sub && sum[10]) begin
                            if (e_inc == 8'hFF) begin
                                acc_nxt = {a_s, 8'hFF, 7'h00};
                                ovf_nxt = 1'b1;
                            end else begin
                                acc_nxt = {a_s, e_inc, res_sig[8:2]};
                            end
                        end else if (res_sig == 10'd0) begin
                            acc_nxt = '0;
                        end else if (res_sig[9]) begin
                            acc_nxt = {a_s, a_e, res_sig[8:2]};
                        end else begin
                            go_norm = 1'b1;
                        end
                    end
                end
                if (go_norm)
                    state_nxt = NORM;
                else
                    state_nxt = (cnt_nxt == '0) ? DONE : ACCEPT;
            end
            NORM: begin
                a_x_nxt = sig_sh;
                a_e_nxt = e_dec;
                if (e_dec == 8'd0) begin
                    acc_nxt   = {a_s, 15'd0};
                    unf_nxt   = 1'b1;
                    state_nxt = (cnt == '0) ? DONE : ACCEPT;
                end else if (sig_sh[9]) begin
                    acc_nxt   = {a_s, e_dec, sig_sh[8:2]};
                    state_nxt = (cnt == '0) ? DONE : ACCEPT;
                end
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            acc_nxt   = '0;
            exc_nxt   = 1'b0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
            cnt_nxt   = len;
            state_nxt = (len == '0) ? DONE : ACCEPT;
        end
        if (exc_nxt)
            out_nxt = 16'h0000;
        else if (ovf_nxt)
            out_nxt = {acc_nxt[15], 8'hFF, 7'h00};
        else
            out_nxt = acc_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            exc_f     <= 1'b0;
            ovf_f     <= 1'b0;
            unf_f     <= 1'b0;
            cnt       <= '0;
            a_s       <= 1'b0;
            a_e       <= '0;
            a_x       <= '0;
            a_y       <= '0;
            a_sub     <= 1'b0;
            t_s       <= 1'b0;
            t_e       <= '0;
            t_m       <= '0;
            t_zero    <= 1'b0;
            t_exc     <= 1'b0;
            t_ovf     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            exc_f     <= exc_nxt;
            ovf_f     <= ovf_nxt;
            unf_f     <= unf_nxt;
            cnt       <= cnt_nxt;
            a_s       <= a_s_nxt;
            a_e       <= a_e_nxt;
            a_x       <= a_x_nxt;
            a_y       <= a_y_nxt;
            a_sub     <= a_sub_nxt;
            out_valid <= (state_nxt == DONE);
            if (state_nxt == DONE)
                out_data <= out_nxt;
            if (state == ACCEPT && in_valid) begin
                t_s    <= in_data[15];
                t_e    <= in_data[14:7];
                t_m    <= in_data[6:0];
                t_zero <= in_unf | (in_data[14:7] == 8'd0);
                t_exc  <= in_exc | ((in_data[14:7] == 8'hFF) & ~in_ovf);
                t_ovf  <= in_ovf;
            end
        end
    end

    assign in_ready = (state == ACCEPT);
    assign busy     = (state != IDLE);
    assign out_exc  = exc_f;
    assign out_ovf  = ovf_f;
    assign out_unf  = unf_f;

endmodule

// File: tb/tb_bf16_acc.sv
// Self-checking bench for bf16_acc: directed corner runs plus random runs scored
// against an integer-arithmetic model of the accumulation rules.
module tb_bf16_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_exc = 1'b0, in_ovf = 1'b0, in_unf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_exc, out_ovf, out_unf;
    logic        busy;

    always #5 clk = ~clk;

    bf16_acc #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_exc(in_exc), .in_ovf(in_ovf), .in_unf(in_unf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc(out_exc), .out_ovf(out_ovf), .out_unf(out_unf), .busy(busy)
    );

    int checks = 0;
    int fails  = 0;

    logic [15:0] t_data [16];
    bit          t_exc  [16];
    bit          t_ovf  [16];
    bit          t_unf  [16];

    logic [15:0] m_data;
    bit          m_exc, m_ovf, m_unf;
    int          m_cycles;
    int          run_cycles, run_taken;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setTerm(input int i, input logic [15:0] data, input bit e, input bit o, input bit u);
        t_data[i] = data; t_exc[i] = e; t_ovf[i] = o; t_unf[i] = u;
    endtask

    task automatic driveTerm(input int i);
        in_data = t_data[i]; in_exc = t_exc[i]; in_ovf = t_ovf[i]; in_unf = t_unf[i];
    endtask

    // Value-level model: magnitudes as integers, significands scaled by 4.
    task automatic modelRun(input int n);
        int acc_s, acc_e, acc_m, ts, te, tm, xs, xe, xm, ys, ye, ym, xsig, ysig, d, s;
        bit zero, tx;
        acc_s = 0; acc_e = 0; acc_m = 0;
        m_exc = 0; m_ovf = 0; m_unf = 0; m_cycles = 0;
        for (int i = 0; i < n; i++) begin
            ts = int'(t_data[i][15]);
            te = int'(t_data[i][14:7]);
            tm = int'(t_data[i][6:0]);
            m_cycles += 3;
            zero = t_unf[i] || (te == 0);
            tx   = t_exc[i] || (te == 255 && !t_ovf[i]);
            if (!m_exc && !m_ovf && !tx) begin
                if (t_ovf[i]) begin
                    acc_s = ts; acc_e = 255; acc_m = 0;
                end else if (!zero) begin
                    if (acc_e * 128 + acc_m >= te * 128 + tm) begin
                        xs = acc_s; xe = acc_e; xm = acc_m; ys = ts; ye = te; ym = tm;
                    end else begin
                        xs = ts; xe = te; xm = tm; ys = acc_s; ye = acc_e; ym = acc_m;
                    end
                    xsig = 512 + xm * 4;
                    ysig = (ye == 0) ? 0 : 512 + ym * 4;
                    d    = xe - ye;
                    ysig = (d >= 10) ? 0 : (ysig >> d);
                    if (xs == ys) begin
                        s = xsig + ysig;
                        if (s >= 1024) begin s = s / 2; xe++; end
                        if (xe == 255) begin
                            m_ovf = 1; acc_s = xs; acc_e = 255; acc_m = 0;
                        end else begin
                            acc_s = xs; acc_e = xe; acc_m = (s / 4) % 128;
                        end
                    end else begin
                        s = xsig - ysig;
                        if (s == 0) begin
                            acc_s = 0; acc_e = 0; acc_m = 0;
                        end else begin
                            while (s < 512 && xe > 0) begin
                                s = s * 2; xe--; m_cycles++;
                            end
                            if (xe == 0) begin
                                acc_s = xs; acc_e = 0; acc_m = 0; m_unf = 1;
                            end else begin
                                acc_s = xs; acc_e = xe; acc_m = (s / 4) % 128;
                            end
                        end
                    end
                end
            end
            m_exc |= tx;
            m_ovf |= t_ovf[i];
        end
        if (m_exc)      m_data = 16'h0000;
        else if (m_ovf) m_data = {acc_s[0], 8'hFF, 7'h00};
        else            m_data = {acc_s[0], acc_e[7:0], acc_m[6:0]};
    endtask

    // Pulses start, then offers terms back to back until a result or the budget runs out.
    task automatic applyStimulus(input int n, input int budget, input bit expect_done);
        int  idx, cyc;
        bit  hs;
        @(posedge clk); #1;
        start = 1'b1; len = 8'(n);
        in_valid = (n > 0);
        if (n > 0) driveTerm(0);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; cyc = 0;
        while (!out_valid && cyc < budget) begin
            hs = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                idx++;
                if (idx < n) driveTerm(idx);
                else         in_valid = 1'b0;
            end
        end
        in_valid   = 1'b0;
        run_cycles = cyc;
        run_taken  = idx;
        if (expect_done) checkOutput("done", 32'(out_valid), 32'd1);
    endtask

    task automatic runCase(input string tag, input int n, input int hold);
        modelRun(n);
        applyStimulus(n, 13 * n + 10, 1'b1);
        checkOutput({tag, "/data"},   32'(out_data),   32'(m_data));
        checkOutput({tag, "/exc"},    32'(out_exc),    32'(m_exc));
        checkOutput({tag, "/ovf"},    32'(out_ovf),    32'(m_ovf));
        checkOutput({tag, "/unf"},    32'(out_unf),    32'(m_unf));
        checkOutput({tag, "/cycles"}, 32'(run_cycles), 32'(m_cycles));
        checkOutput({tag, "/taken"},  32'(run_taken),  32'(n));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "/hold_data"},  32'(out_data),  32'(m_data));
            checkOutput({tag, "/hold_busy"},  32'(busy),      32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "/drop_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "/drop_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        int n;
        int r;
        logic [15:0] w;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst/valid", 32'(out_valid), 32'd0);
        checkOutput("rst/ready", 32'(in_ready),  32'd0);
        checkOutput("rst/busy",  32'(busy),      32'd0);
        checkOutput("rst/data",  32'(out_data),  32'd0);
        checkOutput("rst/flags", 32'({out_exc, out_ovf, out_unf}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'h3F80, 0, 0, 0);
        runCase("one_plus_one", 2, 0);
        checkOutput("one_plus_one/abs", 32'(out_data), 32'h4000);

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'h4000, 0, 0, 0); setTerm(2, 16'hC040, 0, 0, 0);
        runCase("cancel", 3, 0);

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'h3B80, 0, 0, 0);
        runCase("trunc", 2, 0);

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'hBF00, 0, 0, 0);
        runCase("norm1", 2, 0);
        checkOutput("norm1/abs_cycles", 32'(run_cycles), 32'd7);

        setTerm(0, 16'h7F7F, 0, 0, 0); setTerm(1, 16'h7F7F, 0, 0, 0);
        runCase("ovf", 2, 0);

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'h4000, 1, 0, 0); setTerm(2, 16'h3F80, 0, 0, 0);
        runCase("exc", 3, 0);

        setTerm(0, 16'h8180, 0, 0, 0); setTerm(1, 16'h017F, 0, 0, 0);
        runCase("unf", 2, 0);

        runCase("len0", 0, 0);

        setTerm(0, 16'h4040, 0, 0, 0); setTerm(1, 16'hBF00, 0, 0, 0);
        runCase("hold", 2, 5);

        for (int k = 0; k < 20; k++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                r = int'($urandom_range(0, 15));
                w = 16'($urandom);
                w[14:7] = 8'($urandom_range(118, 136));
                if (r == 3) w[14:7] = 8'h00;
                if (r == 4) w[14:7] = 8'hFF;
                setTerm(i, w, r == 0, r == 1, r == 2);
            end
            runCase("random", n, 0);
        end

        setTerm(0, 16'h3F80, 0, 0, 0); setTerm(1, 16'hBF7F, 0, 0, 0);
        applyStimulus(2, 8, 1'b0);
        checkOutput("midnorm/busy",  32'(busy),      32'd1);
        checkOutput("midnorm/ready", 32'(in_ready),  32'd0);
        checkOutput("midnorm/valid", 32'(out_valid), 32'd0);
        setTerm(0, 16'h4040, 0, 0, 0);
        runCase("restart", 1, 0);
        checkOutput("restart/abs", 32'(out_data), 32'h4040);

        setTerm(0, 16'h3F80, 0, 0, 0);
        applyStimulus(1, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst/busy",  32'(busy),      32'd0);
        checkOutput("arst/ready", 32'(in_ready),  32'd0);
        checkOutput("arst/valid", 32'(out_valid), 32'd0);
        checkOutput("arst/data",  32'(out_data),  32'd0);
        checkOutput("arst/flags", 32'({out_exc, out_ovf, out_unf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        setTerm(0, 16'hC0A0, 0, 0, 0);
        runCase("recover", 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
